// File: rtl/string_fifo_cmp_avalon.sv
// Avalon-MM slave with two 32-bit word FIFOs and a byte-wise string compare engine.
// Optional completion interrupt port enabled by defining STRING_FIFO_IRQ_EN.
module string_fifo_cmp_avalon #(
  parameter int          DEPTH    = 16,
  parameter logic [31:0] DEADWORD = 32'hDEADFACE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        read,
  input  logic        write,
  input  logic [2:0]  address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata
`ifdef STRING_FIFO_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_C = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE_C  = (AW+1)'(1);
  localparam logic [AW-1:0] ONE_P  = AW'(1);

  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;

  logic [31:0]   mem_a [DEPTH];
  logic [31:0]   mem_b [DEPTH];
  logic [AW-1:0] wp_a, rp_a, wp_b, rp_b;
  logic [AW:0]   cnt_a, cnt_b;
  logic          ovf, done, pend, pend_eq, res_eq, irq_en;
  logic [15:0]   res_idx, base;

  logic wr_acc, rd_acc, busy, flush, clr_done, ctrl_acc, go;
  logic empty_a, empty_b, full_a, full_b;
  logic push_a, push_b, bpop_a, bpop_b, last_a, last_b;
  logic [31:0] head_a, head_b, status, result;
  logic        hit, hit_eq;
  logic [1:0]  hit_k;
  logic [16:0] sum_k, sum_4;
  logic [15:0] idx_k, base4;

  assign wr_acc   = chipselect & write;
  assign rd_acc   = chipselect & read;
  assign busy     = (state_q == RUN);
  assign flush    = wr_acc && (address == 3'd2) && writedata[0];
  assign clr_done = wr_acc && (address == 3'd2) && writedata[1];
  assign ctrl_acc = wr_acc && (address == 3'd3) && !busy;
  assign go       = ctrl_acc && writedata[0];
  assign empty_a  = (cnt_a == '0);
  assign empty_b  = (cnt_b == '0);
  assign full_a   = (cnt_a == FULL_C);
  assign full_b   = (cnt_b == FULL_C);
  assign push_a   = wr_acc && (address == 3'd0) && !busy;
  assign push_b   = wr_acc && (address == 3'd1) && !busy;
  assign bpop_a   = rd_acc && (address == 3'd0) && !busy && !empty_a;
  assign bpop_b   = rd_acc && (address == 3'd1) && !busy && !empty_b;
  assign last_a   = (cnt_a == ONE_C);
  assign last_b   = (cnt_b == ONE_C);
  assign head_a   = mem_a[rp_a];
  assign head_b   = mem_b[rp_b];

  assign status = {8'(cnt_a), 8'(cnt_b), 7'b0, ovf, full_b, empty_b, full_a, empty_a,
                   2'b0, busy, done};
  assign result = {res_eq, 15'b0, res_idx};

`ifdef STRING_FIFO_IRQ_EN
  assign irq = done & irq_en;
`endif

  // First byte (MSB first) that either differs or is a shared NUL terminator.
  always_comb begin
    hit    = 1'b0;
    hit_eq = 1'b0;
    hit_k  = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      if (!hit) begin
        if (head_a[31-8*k -: 8] != head_b[31-8*k -: 8]) begin
          hit   = 1'b1;
          hit_k = 2'(k);
        end else if (head_a[31-8*k -: 8] == 8'h00) begin
          hit    = 1'b1;
          hit_eq = 1'b1;
          hit_k  = 2'(k);
        end
      end
    end
  end

  assign sum_k = {1'b0, base} + {15'b0, hit_k};
  assign sum_4 = {1'b0, base} + 17'd4;
  assign idx_k = sum_k[16] ? 16'hFFFF : sum_k[15:0];
  assign base4 = sum_4[16] ? 16'hFFFF : sum_4[15:0];

  always_comb begin
    state_d = state_q;
    if (flush)
      state_d = IDLE;
    else if (busy && (hit || last_a || last_b))
      state_d = IDLE;
    else if (!busy && go && !empty_a && !empty_b)
      state_d = RUN;
  end

  always_ff @(posedge clk) begin
    if (push_a && !full_a) mem_a[wp_a] <= writedata;
    if (push_b && !full_b) mem_b[wp_b] <= writedata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      wp_a <= '0; rp_a <= '0; cnt_a <= '0;
      wp_b <= '0; rp_b <= '0; cnt_b <= '0;
      ovf <= 1'b0; done <= 1'b0; pend <= 1'b0; pend_eq <= 1'b0;
      res_eq <= 1'b0; res_idx <= '0; base <= '0; irq_en <= 1'b0;
    end else if (flush) begin
      state_q <= IDLE;
      wp_a <= '0; rp_a <= '0; cnt_a <= '0;
      wp_b <= '0; rp_b <= '0; cnt_b <= '0;
      ovf <= 1'b0; done <= 1'b0; pend <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((push_a && full_a) || (push_b && full_b)) ovf <= 1'b1;
      if (push_a && !full_a) begin
        wp_a  <= wp_a + ONE_P;
        cnt_a <= cnt_a + ONE_C;
      end
      if (push_b && !full_b) begin
        wp_b  <= wp_b + ONE_P;
        cnt_b <= cnt_b + ONE_C;
      end
      if (bpop_a || busy) begin
        rp_a  <= rp_a + ONE_P;
        cnt_a <= cnt_a - ONE_C;
      end
      if (bpop_b || busy) begin
        rp_b  <= rp_b + ONE_P;
        cnt_b <= cnt_b - ONE_C;
      end
      if (clr_done) done <= 1'b0;
      if (ctrl_acc) irq_en <= writedata[1];
      if (go) begin
        done    <= 1'b0;
        res_eq  <= 1'b0;
        res_idx <= '0;
        base    <= '0;
        pend    <= empty_a || empty_b;
        pend_eq <= empty_a && empty_b;
      end else if (pend) begin
        pend    <= 1'b0;
        done    <= 1'b1;
        res_eq  <= pend_eq;
        res_idx <= '0;
      end else if (busy) begin
        if (hit) begin
          res_eq  <= hit_eq;
          res_idx <= idx_k;
          done    <= 1'b1;
        end else begin
          base <= base4;
          if (last_a || last_b) begin
            res_eq  <= last_a && last_b;
            res_idx <= base4;
            done    <= 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata <= '0;
    end else if (rd_acc) begin
      case (address)
        3'd0:    readdata <= (busy || empty_a) ? DEADWORD : head_a;
        3'd1:    readdata <= (busy || empty_b) ? DEADWORD : head_b;
        3'd2:    readdata <= status;
        3'd3:    readdata <= result;
        default: readdata <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_string_fifo_cmp_avalon.sv
// Scoreboard bench for string_fifo_cmp_avalon (DEPTH=4): stimulus queues expected
// {irq, readdata}; a negedge monitor compares each registered read response.
module tb_string_fifo_cmp_avalon;

`ifdef STRING_FIFO_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        chipselect = 1'b0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [2:0]  address = '0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        irq;

  always #5 clk = ~clk;

  string_fifo_cmp_avalon #(.DEPTH(4), .DEADWORD(32'hDEADFACE)) dut (
    .clk        (clk),
    .reset      (reset),
    .chipselect (chipselect),
    .read       (read),
    .write      (write),
    .address    (address),
    .writedata  (writedata),
    .readdata   (readdata)
`ifdef STRING_FIFO_IRQ_EN
    ,
    .irq        (irq)
`endif
  );

`ifndef STRING_FIFO_IRQ_EN
  assign irq = 1'b0;
`endif

  logic [32:0] exp_q [$];
  string       name_q [$];
  logic        rd_q = 1'b0;
  logic        stim_done = 1'b0;
  int          vectors = 0;
  int          miscompares = 0;

  always @(posedge clk) rd_q <= chipselect & read;

  always @(negedge clk) begin
    logic [32:0] e;
    string       n;
    if (rd_q) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_read: got %h, required no response", readdata);
      end else begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        if ({irq, readdata} !== e)
          begin
            miscompares++;
            $display("FAIL %s: got irq=%b data=%h, required irq=%b data=%h",
                     n, irq, readdata, e[32], e[31:0]);
          end
      end
    end else if (stim_done) begin
      vectors++;
      if (exp_q.size() != 0) begin
        miscompares++;
        $display("FAIL pending_reads: got %0d outstanding, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog");
  end

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(posedge clk); #1;
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, input logic [31:0] e, input bit ei,
                          input string n);
    chipselect = 1'b1; read = 1'b1; address = a;
    exp_q.push_back({ei & IRQ_ON, e});
    name_q.push_back(n);
    @(posedge clk); #1;
    chipselect = 1'b0; read = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    idle(1);

    // reset state and unmapped addresses
    bus_read(3'd2, 32'h00000050, 0, "reset_status");
    bus_read(3'd3, 32'h00000000, 0, "reset_result");
    bus_write(3'd6, 32'hFFFFFFFF);
    bus_read(3'd6, 32'h00000000, 0, "unmapped_read");
    bus_read(3'd0, 32'hDEADFACE, 0, "empty_pop_a");

    // "Hello" vs "Hello": NUL terminator at byte 5, two RUN cycles
    bus_write(3'd0, 32'h48656C6C); bus_write(3'd0, 32'h6F000000);
    bus_write(3'd1, 32'h48656C6C); bus_write(3'd1, 32'h6F000000);
    bus_write(3'd3, 32'h00000003);
    bus_read(3'd2, 32'h02020002, 0, "hello_run1");
    bus_read(3'd2, 32'h01010002, 1, "hello_run2");
    bus_read(3'd2, 32'h00000051, 1, "hello_done");
    bus_read(3'd3, 32'h80000005, 1, "hello_result");

    // mismatch at byte 2
    bus_write(3'd0, 32'h41424344); bus_write(3'd1, 32'h41425844);
    bus_write(3'd3, 32'h00000001);
    idle(3);
    bus_read(3'd3, 32'h00000002, 0, "mismatch_result");
    bus_read(3'd2, 32'h00000051, 0, "mismatch_status");
    bus_read(3'd1, 32'hDEADFACE, 0, "mismatch_b_empty");

    // A longer than B, all bytes equal and non-NUL
    bus_write(3'd0, 32'h01020304); bus_write(3'd0, 32'h05060708);
    bus_write(3'd1, 32'h01020304);
    bus_write(3'd3, 32'h00000001);
    idle(3);
    bus_read(3'd3, 32'h00000004, 0, "uneven_result");
    bus_read(3'd2, 32'h01000041, 0, "uneven_status");
    bus_write(3'd2, 32'h00000001);
    bus_read(3'd2, 32'h00000050, 0, "flush_status");

    // overflow on a DEPTH=4 FIFO
    for (int i = 1; i <= 5; i++) bus_write(3'd0, 32'h11111111 * i);
    bus_read(3'd2, 32'h04000160, 0, "ovf_status");
    for (int i = 1; i <= 4; i++) bus_read(3'd0, 32'h11111111 * i, 0, "ovf_pop");
    bus_read(3'd0, 32'hDEADFACE, 0, "ovf_pop_empty");
    bus_read(3'd2, 32'h00000150, 0, "ovf_after_pops");

    // go with one or both FIFOs empty skips RUN
    bus_write(3'd2, 32'h00000001);
    bus_write(3'd0, 32'hCAFEBABE);
    bus_write(3'd3, 32'h00000001);
    bus_read(3'd2, 32'h01000040, 0, "skip_pending");
    bus_read(3'd2, 32'h01000041, 0, "skip_done");
    bus_read(3'd3, 32'h00000000, 0, "skip_one_empty");
    bus_write(3'd2, 32'h00000001);
    bus_write(3'd3, 32'h00000001);
    idle(1);
    bus_read(3'd3, 32'h80000000, 0, "skip_both_empty");
    bus_write(3'd2, 32'h00000002);
    bus_read(3'd2, 32'h00000050, 0, "clear_done");

    // pointer wrap: 6 rounds of 3 pushes then 3 pops
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 3; i++) bus_write(3'd1, 32'hB0000000 + 32'(r * 16 + i));
      for (int i = 0; i < 3; i++) bus_read(3'd1, 32'hB0000000 + 32'(r * 16 + i), 0, "wrap_pop");
    end
    bus_read(3'd2, 32'h00000050, 0, "wrap_status");

    // flush during RUN aborts with no done / irq
    bus_write(3'd0, 32'h01010101); bus_write(3'd0, 32'h02020202);
    bus_write(3'd1, 32'h01010101); bus_write(3'd1, 32'h02020202);
    bus_write(3'd3, 32'h00000003);
    bus_write(3'd2, 32'h00000001);
    bus_read(3'd2, 32'h00000050, 0, "abort_status");
    idle(3);
    bus_read(3'd2, 32'h00000050, 0, "abort_no_done");

    idle(2);
    stim_done = 1'b1;
  end

endmodule

// File: doc/string_fifo_cmp_avalon.md
STRING_FIFO_CMP_AVALON -- requirements
Module: string_fifo_cmp_avalon

Interface
REQ-001 SHALL have parameter: DEPTH, 16, words per FIFO; power of two, 2..128.
REQ-002 SHALL have parameter: DEADWORD, 32'hDEADFACE, readdata returned on an illegal pop.
REQ-003 SHALL have port: clk  in  1  the only clock; all state is updated on its rising edge.
REQ-004 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port: chipselect  in  1  Avalon-MM slave select.
REQ-006 SHALL have port: read  in  1  read strobe, one cycle per access.
REQ-007 SHALL have port: write  in  1  write strobe, one cycle per access.
REQ-008 SHALL have port: address  in  3  register index; 4..7 read 0 and ignore writes.
REQ-009 SHALL have port: writedata  in  32  write data.
REQ-010 SHALL have port: readdata  out  32  registered read data.
REQ-011 SHALL have port: irq  out  1  completion interrupt; exists only under STRING_FIFO_IRQ_EN.

Function
REQ-012 SHALL provide register map: 0 FIFO A data; 1 FIFO B data; 2 STATUS; 3 CTRL on write, RESULT on read.
REQ-013 SHALL push writedata into FIFO A/B on a chipselect&write to address 0/1 while idle; a push when full is dropped and sets sticky ovf.
REQ-014 SHALL pop exactly one word per chipselect&read cycle to address 0/1, and present the head on readdata in the next cycle (latency 1).
REQ-015 SHALL return DEADWORD without popping on a read of an empty FIFO, or on any FIFO read while busy.
REQ-016 SHALL ignore pushes to either FIFO, and CTRL writes, while busy.
REQ-017 SHALL keep independent rd/wr pointers per FIFO, each wrapping modulo DEPTH, and a count 0..DEPTH; full = count==DEPTH, empty = count==0.
REQ-018 SHALL read STATUS as [31:24] countA, [23:16] countB, [8] ovf, [7] fullB, [6] emptyB, [5] fullA, [4] emptyA, [1] busy, [0] done.
REQ-019 SHALL on a STATUS write with wd[0]=1 flush both FIFOs and ovf, abort any run to IDLE, and clear done.
REQ-020 SHALL on a STATUS write with wd[1]=1 clear done only.
REQ-021 SHALL on a CTRL write with wd[0]=1 (go) in IDLE clear done and enter RUN; go while busy is ignored.
REQ-022 SHALL use FSM states IDLE and RUN; busy = RUN.
REQ-023 SHALL, on go with either FIFO empty, skip RUN and in the next cycle set done, equal = (both empty), index = 0.
REQ-024 SHALL in RUN pop one word from each FIFO per cycle and compare bytes in order [31:24], [23:16], [15:8], [7:0], with byte offset base+k.
REQ-025 SHALL, at the first mismatching byte k, set equal=0 and index=base+k, set done, and go to IDLE; remaining FIFO words are retained.
REQ-026 SHALL, at the first byte k where A and B both hold 8'h00 and all earlier bytes match, set equal=1 and index=base+k, set done, and go to IDLE.
REQ-027 SHALL otherwise add 4 to base; if both FIFOs are now empty, set equal=1; if only one is empty, set equal=0; in either case set index=base, done=1, and go to IDLE.
REQ-028 SHALL read RESULT as [31] equal, [15:0] index, with other bits 0; RESULT holds until the next go or reset.
REQ-029 SHALL make index 16 bits wide, with base saturating at 16'hFFFF.
REQ-030 SHALL give a STATUS flush priority over an in-flight RUN pop in the same cycle.

Reset
REQ-031 SHALL asynchronously force readdata=0, all pointers/counts=0, ovf=0, done=0, RESULT=0, state=IDLE, irq=0, irq_en=0; FIFO storage is not reset.
REQ-032 SHALL discard a run in progress on reset, with no done and no irq.

Configuration
REQ-033 SHALL, with STRING_FIFO_IRQ_EN defined, add port irq = done & irq_en, with irq_en loaded from CTRL wd[1] on every accepted CTRL write.
REQ-034 SHALL, without STRING_FIFO_IRQ_EN, omit port irq and ignore CTRL wd[1]; all other behaviour is identical.

Verification
REQ-035 SHALL cover: push A,B each 32'h48656C6C,32'h6F000000; go -> done after 2 RUN cycles, RESULT=32'h80000005.
REQ-036 SHALL cover: A=32'h41424344, B=32'h41425844; go -> RESULT=32'h00000002; FIFOs empty, countA=countB=0.
REQ-037 SHALL cover: DEPTH=4; 5 pushes to A -> countA=4, fullA=1, ovf=1; 4 pops return the first 4 words in order; 5th pop returns 32'hDEADFACE, countA stays 0.
REQ-038 SHALL cover: A holds 2 words, B holds 1 word, all bytes equal and non-NUL -> RESULT=32'h00000004, countA=1.
REQ-039 SHALL cover: push 3 words then pop 3, repeated 6 times with DEPTH=4 -> pointer wrap is correct and all data is returned in order.
REQ-040 SHALL cover: go, then STATUS write 32'h1 during RUN -> busy=0, done=0, counts 0; with STRING_FIFO_IRQ_EN, irq stays 0.
